up_counter_seq: RTL and testbench



---
 rtl/up_counter_seq.sv | 187 ++++++++++++++++++
 tb/tb_up_counter_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_counter_seq.sv
// up_counter_seq
//
// Sequencing controller for an external CNT_W-bit up counter. A start
// command carries a target count and a repeat count. The controller then
// repeatedly clears the counter, lets it count up to the target, and
// compares. After the requested number of runs it pulses done. It owns
// the counter's reset (cnt_rst_h) and enable (cnt_en).
//
// Optional build macro:
//   UP_COUNTER_SEQ_HOLD_EN
//     When defined, the counter is not cleared when the final run
//     completes, so cnt_out keeps showing target after done.
//     When undefined, the DONE cycle clears the counter.
//
// Ports:
//   clk        clock; all logic on posedge
//   rst_h      synchronous active-high reset
//   start      command strobe; sampled only in IDLE
//   target     terminal count per run; latched on accepted start
//   reps       number of runs; latched on accepted start; 0 means 1
//   abort      cancel the current sequence (priority over start in IDLE)
//   busy       high in any state other than IDLE
//   done       one-cycle pulse when all runs complete
//   err        sticky error flag; cleared by the next accepted start
//   rep_cnt    completed runs in the current sequence
//   cnt_rst_h  reset to the counter
//   cnt_en     count enable to the counter
//   cnt_out    counter value
module up_counter_seq #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_h,
  input  logic             start,
  input  logic [CNT_W-1:0] target,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [REP_W-1:0] rep_cnt,
  output logic             cnt_rst_h,
  output logic             cnt_en,
  input  logic [CNT_W-1:0] cnt_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] target_q,  target_d;
  logic [REP_W-1:0] reps_q,    reps_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             err_q,     err_d;

  logic             at_target;
  logic             overshoot;
  logic [REP_W-1:0] rep_next;
  logic             last_run;
  logic             active;
  logic             done_clear;

  // Unsigned CNT_W-bit comparisons against the latched target.
  assign at_target = (cnt_out == target_q);
  assign overshoot = (cnt_out >  target_q);

  // reps_q never exceeds 2^REP_W-1, so rep_cnt cannot wrap.
  assign rep_next  = rep_cnt_q + REP_W'(1);
  assign last_run  = (rep_next == reps_q);

  assign active    = (state_q == S_CLR) || (state_q == S_RUN);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    reps_d    = reps_q;
    rep_cnt_d = rep_cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort wins over start: the command is dropped entirely.
        if (!abort && start) begin
          if (target != '0) begin
            target_d  = target;
            reps_d    = (reps == '0) ? REP_W'(1) : reps;
            rep_cnt_d = '0;
            err_d     = 1'b0;
            state_d   = S_CLR;
          end else begin
            err_d     = 1'b1;
          end
        end
      end

      S_CLR: begin
        state_d = abort ? S_IDLE : S_RUN;
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (overshoot) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (at_target) begin
          rep_cnt_d = rep_next;
          if (last_run) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_CLR;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_h) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      reps_q    <= '0;
      rep_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      reps_q    <= reps_d;
      rep_cnt_q <= rep_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Counter control. Combinational so the counter is cleared on the same
  // edge that the controller leaves a run (abort, overshoot, reset).
  // ---------------------------------------------------------------------
`ifdef UP_COUNTER_SEQ_HOLD_EN
  assign done_clear = 1'b0;
`else
  assign done_clear = (state_q == S_DONE);
`endif

  always_comb begin
    cnt_rst_h = rst_h
              || (state_q == S_CLR)
              || (active && abort)
              || ((state_q == S_RUN) && overshoot)
              || done_clear;
    cnt_en    = !rst_h && (state_q == S_RUN) && !abort && !at_target;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rep_cnt = rep_cnt_q;

endmodule

// File: tb/tb_up_counter_seq.sv
module tb_up_counter_seq;

  logic       clk;
  logic       rst_h;
  logic       start;
  logic [3:0] target;
  logic [3:0] reps;
  logic       abort;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] rep_cnt;
  logic       cnt_rst_h;
  logic       cnt_en;
  logic [3:0] cnt_out;

  // Stand-in 4-bit counter plus an override used to force an overshoot.
  logic [3:0] cnt_q;
  logic       force_en;
  logic [3:0] force_val;

  int n_checks;
  int n_fail;

`ifdef UP_COUNTER_SEQ_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  up_counter_seq #(.CNT_W(4), .REP_W(4)) dut (
    .clk       (clk),
    .rst_h     (rst_h),
    .start     (start),
    .target    (target),
    .reps      (reps),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rep_cnt   (rep_cnt),
    .cnt_rst_h (cnt_rst_h),
    .cnt_en    (cnt_en),
    .cnt_out   (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_rst_h)   cnt_q <= 4'd0;
    else if (cnt_en) cnt_q <= cnt_q + 4'd1;
  end

  assign cnt_out = force_en ? force_val : cnt_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] obs;
    rst_h = 1'b1;
    tick();
    tick();
    obs = {busy, done, err, cnt_en, cnt_rst_h, rep_cnt[2:0]};
    n_checks++;
    if (obs !== 8'b0000_1000) begin
      n_fail++;
      $display("FAIL reset_held: got %b expected %b", obs, 8'b0000_1000);
    end
    rst_h = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {busy, done, err, cnt_en, cnt_rst_h, rep_cnt[2:0]};
      n_checks++;
      if (obs !== 8'b0 || rep_cnt !== 4'd0 || cnt_out !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got %b rep=%0d cnt=%0d expected 0", i, obs, rep_cnt, cnt_out);
      end
    end
  endtask

  // ------------------------------------------------------------------
  // Full sequence against a timeline derived from the per-run latency:
  // each run is P = target+2 cycles (CLR, target counting cycles, compare),
  // then one DONE cycle, then IDLE.
  task automatic test_sequence(input int unsigned t, input int unsigned rp,
                               input bit junk, input bit abort_done);
    int unsigned rr;
    int unsigned p;
    int unsigned last;
    logic [8:0]  exp_c;
    logic [8:0]  obs_c;
    logic [3:0]  exp_cnt;
    bit          chk_cnt;
    bit          e_busy, e_done, e_rst, e_en;
    logic [3:0]  e_rep;

    rr   = (rp == 0) ? 1 : rp;
    p    = t + 2;
    last = rr * p;

    target = 4'(t);
    reps   = 4'(rp);
    start  = 1'b1;
    tick();
    start  = 1'b0;

    for (int unsigned n = 0; n <= last + 1; n++) begin
      int unsigned r;
      int unsigned m;
      r = n / p;
      m = n % p;
      e_busy  = (n <= last);
      e_done  = (n == last);
      chk_cnt = 1'b1;
      exp_cnt = 4'd0;
      if (n < last) begin
        e_rst = (m == 0);
        e_en  = (m >= 1) && ((m - 1) != t);
        e_rep = 4'(r);
        if (m >= 1)      exp_cnt = 4'(m - 1);
        else if (r >= 1) exp_cnt = 4'(t);
        else             chk_cnt = 1'b0;
      end else if (n == last) begin
        e_rst   = !HOLD;
        e_en    = 1'b0;
        e_rep   = 4'(rr);
        exp_cnt = 4'(t);
      end else begin
        e_rst   = 1'b0;
        e_en    = 1'b0;
        e_rep   = 4'(rr);
        exp_cnt = HOLD ? 4'(t) : 4'd0;
      end

      exp_c = {e_busy, e_done, 1'b0, e_rst, e_en, e_rep};
      obs_c = {busy, done, err, cnt_rst_h, cnt_en, rep_cnt};
      n_checks++;
      if (obs_c !== exp_c) begin
        n_fail++;
        $display("FAIL seq_ctrl t=%0d reps=%0d n=%0d: got busy/done/err/rst/en/rep=%b expected %b",
                 t, rp, n, obs_c, exp_c);
      end
      if (chk_cnt) begin
        n_checks++;
        if (cnt_out !== exp_cnt) begin
          n_fail++;
          $display("FAIL seq_cnt t=%0d reps=%0d n=%0d: got %0d expected %0d",
                   t, rp, n, cnt_out, exp_cnt);
        end
      end

      if (junk && n < last) begin
        start  = 1'($urandom_range(0, 1));
        target = 4'($urandom_range(0, 15));
        reps   = 4'($urandom_range(0, 15));
      end
      if (n == last) begin
        start = 1'b0;
        if (abort_done) begin
          abort = 1'b1;
          #1;
          n_checks++;
          if (cnt_rst_h !== !HOLD) begin
            n_fail++;
            $display("FAIL abort_in_done: cnt_rst_h got %b expected %b", cnt_rst_h, !HOLD);
          end
        end
      end
      if (n <= last) begin
        tick();
        abort = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  // ------------------------------------------------------------------
  task automatic test_target_zero();
    target = 4'd0;
    reps   = 4'd2;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({err, busy, done, cnt_rst_h} !== 4'b1000) begin
        n_fail++;
        $display("FAIL target_zero[%0d]: err/busy/done/rst got %b expected 1000",
                 i, {err, busy, done, cnt_rst_h});
      end
      tick();
    end
  endtask

  task automatic test_abort_idle();
    // err is 1 from the preceding zero-target command; a dropped start keeps it.
    target = 4'd4;
    reps   = 4'd1;
    start  = 1'b1;
    abort  = 1'b1;
    tick();
    start  = 1'b0;
    abort  = 1'b0;
    n_checks++;
    if ({busy, err, done} !== 3'b010) begin
      n_fail++;
      $display("FAIL abort_idle: busy/err/done got %b expected 010", {busy, err, done});
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle_later: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    target = 4'd15;
    reps   = 4'd2;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int n = 0; n < 8; n++) begin
      start  = 1'($urandom_range(0, 1));
      target = 4'($urandom_range(0, 15));
      reps   = 4'($urandom_range(0, 15));
      tick();
    end
    start = 1'b0;
    n_checks++;
    if (cnt_out !== 4'd7 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: cnt=%0d busy=%b expected cnt=7 busy=1", cnt_out, busy);
    end
    abort = 1'b1;
    #1;
    n_checks++;
    if ({cnt_rst_h, cnt_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_cycle: rst/en got %b expected 10", {cnt_rst_h, cnt_en});
    end
    tick();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({busy, done, err, cnt_rst_h} !== 4'b0000 || rep_cnt !== 4'd0 || cnt_out !== 4'd0) begin
        n_fail++;
        $display("FAIL abort_after[%0d]: busy/done/err/rst=%b rep=%0d cnt=%0d expected 0000 rep=0 cnt=0",
                 i, {busy, done, err, cnt_rst_h}, rep_cnt, cnt_out);
      end
      tick();
    end
  endtask

  task automatic test_overshoot();
    target = 4'd6;
    reps   = 4'd1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    tick();
    force_val = 4'd9;
    force_en  = 1'b1;
    #1;
    n_checks++;
    if (cnt_rst_h !== 1'b1) begin
      n_fail++;
      $display("FAIL overshoot_cycle: cnt_rst_h got %b expected 1", cnt_rst_h);
    end
    tick();
    force_en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({busy, done, err} !== 3'b001 || cnt_out !== 4'd0) begin
        n_fail++;
        $display("FAIL overshoot_after[%0d]: busy/done/err=%b cnt=%0d expected 001 cnt=0",
                 i, {busy, done, err}, cnt_out);
      end
      tick();
    end
  endtask

  task automatic test_midreset();
    target = 4'd10;
    reps   = 4'd2;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_h = 1'b1;
    #1;
    n_checks++;
    if ({cnt_rst_h, cnt_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL midreset_cycle: rst/en got %b expected 10", {cnt_rst_h, cnt_en});
    end
    tick();
    rst_h = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, err, cnt_rst_h} !== 4'b0000 || rep_cnt !== 4'd0 || cnt_out !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_after: busy/done/err/rst=%b rep=%0d cnt=%0d expected 0000 0 0",
               {busy, done, err, cnt_rst_h}, rep_cnt, cnt_out);
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      test_sequence($urandom_range(1, 15), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  // ------------------------------------------------------------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_h     = 1'b1;
    start     = 1'b0;
    target    = 4'd0;
    reps      = 4'd0;
    abort     = 1'b0;
    force_en  = 1'b0;
    force_val = 4'd0;

    test_reset();
    test_sequence(5, 1, 1'b0, 1'b0);
    test_sequence(3, 3, 1'b0, 1'b0);
    test_target_zero();
    test_abort_idle();
    test_sequence(4, 0, 1'b1, 1'b1);
    test_abort();
    test_overshoot();
    test_sequence(15, 2, 1'b1, 1'b0);
    test_midreset();
    test_random();
    test_sequence(1, 15, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
